// File: rtl/reg_file_banked.sv
// -----------------------------------------------------------------------------
// reg_file_banked
//
// Banked register file with one write port and two combinational read ports.
// NUM_BANKS banks of DEPTH x WIDTH registers; the active bank is picked by an
// internal pointer that BANK_ADV steps (modulo NUM_BANKS) for fast context
// switching. A clear sequencer zeroes one entry per cycle in all banks at once
// after reset or on a CLR request.
//
// Ports:
//   CLK       sole clock, rising edge
//   RST       synchronous active-high reset (state -> clear, bank pointer -> 0)
//   CLR       single-cycle request to (re)start the clear sequence
//   DIN       write data
//   RF_WR     write enable, DIN -> active bank entry ADRX
//   ADRX      write address and X read address
//   ADRY      Y read address
//   BANK_ADV  advance active bank pointer by one
//   DX_OUT    active bank entry at ADRX (0 while clearing)
//   DY_OUT    active bank entry at ADRY (0 while clearing)
//   BANK      active bank pointer
//   BUSY      clear sequence in progress
// -----------------------------------------------------------------------------
module reg_file_banked #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned NUM_BANKS = 2,
   localparam int unsigned ADDR_W   = $clog2(DEPTH),
   localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR,
   input  logic [WIDTH-1:0]  DIN,
   input  logic              RF_WR,
   input  logic [ADDR_W-1:0] ADRX,
   input  logic [ADDR_W-1:0] ADRY,
   input  logic              BANK_ADV,
   output logic [WIDTH-1:0]  DX_OUT,
   output logic [WIDTH-1:0]  DY_OUT,
   output logic [BANK_W-1:0] BANK,
   output logic              BUSY
);

   typedef enum logic {StClear, StIdle} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [BANK_W-1:0] bank_q, bank_d;
   logic [WIDTH-1:0]  mem_q [NUM_BANKS][DEPTH];

   logic clr_step;
   logic wr_en;

   // Next-state logic. CLR outranks the normal state behaviour; RST outranks
   // everything and is applied in the register process.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      bank_d   = bank_q;
      clr_step = 1'b0;
      wr_en    = 1'b0;
      if (CLR) begin
         state_d = StClear;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            StClear: begin
               clr_step = 1'b1;
               if (idx_q == ADDR_W'(DEPTH - 1)) begin
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
            StIdle: begin
               wr_en = RF_WR;
               if (BANK_ADV) begin
                  // Wrap explicitly so non-power-of-2 bank counts also work.
                  bank_d = (bank_q == BANK_W'(NUM_BANKS - 1)) ? '0 : bank_q + BANK_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StClear;
         idx_q   <= '0;
         bank_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bank_q  <= bank_d;
      end
   end

   // Storage has no reset; the clear sequencer is what zeroes it. Writes use
   // bank_q, i.e. the pointer value before a simultaneous BANK_ADV.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (clr_step) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
               mem_q[BANK_W'(b)][idx_q] <= '0;
            end
         end else if (wr_en) begin
            mem_q[bank_q][ADRX] <= DIN;
         end
      end
   end

   assign BUSY   = (state_q == StClear);
   assign BANK   = bank_q;
   // No write-through bypass: reads see stored contents only.
   assign DX_OUT = BUSY ? '0 : mem_q[bank_q][ADRX];
   assign DY_OUT = BUSY ? '0 : mem_q[bank_q][ADRY];

endmodule

// File: tb/tb_reg_file_banked.sv
// -----------------------------------------------------------------------------
// tb_reg_file_banked
//
// Self-checking bench for reg_file_banked: a default instance (8x32x2) and a
// sweep instance (16x8x4). A reference model of the register contents and bank
// pointer supplies expected read data through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_reg_file_banked;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance
   logic       rst = 1'b1, clr = 1'b0, wr = 1'b0, adv = 1'b0;
   logic [7:0] din = '0;
   logic [4:0] adrx = '0, adry = '0;
   logic [7:0] dx, dy;
   logic [0:0] bank;
   logic       busy;

   // Sweep instance
   logic        rst2 = 1'b1, clr2 = 1'b0, wr2 = 1'b0, adv2 = 1'b0;
   logic [15:0] din2 = '0;
   logic [2:0]  adrx2 = '0, adry2 = '0;
   logic [15:0] dx2, dy2;
   logic [1:0]  bank2;
   logic        busy2;

   reg_file_banked dut (
      .CLK(clk), .RST(rst), .CLR(clr), .DIN(din), .RF_WR(wr), .ADRX(adrx), .ADRY(adry),
      .BANK_ADV(adv), .DX_OUT(dx), .DY_OUT(dy), .BANK(bank), .BUSY(busy)
   );

   reg_file_banked #(.WIDTH(16), .DEPTH(8), .NUM_BANKS(4)) dut2 (
      .CLK(clk), .RST(rst2), .CLR(clr2), .DIN(din2), .RF_WR(wr2), .ADRX(adrx2), .ADRY(adry2),
      .BANK_ADV(adv2), .DX_OUT(dx2), .DY_OUT(dy2), .BANK(bank2), .BUSY(busy2)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] e;
   logic [7:0]  model [2][32];
   int          mbank = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 32; a++) model[b][a] = 8'h00;
   endtask

   task automatic do_wr(input int a, input logic [7:0] d);
      wr = 1'b1; adrx = 5'(a); din = d;
      tick();
      wr = 1'b0;
      model[mbank][a] = d;
   endtask

   task automatic do_adv();
      adv = 1'b1;
      tick();
      adv = 1'b0;
      mbank = (mbank + 1) % 2;
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      adrx = 5'd3; adry = 5'd9;
      #1;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
      n_checks++;
      if (bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank: got %0d expected 0", bank); end
      n_checks++;
      if (dx !== 8'h00 || dy !== 8'h00) begin
         n_fail++; $display("FAIL reset_out: got dx=%h dy=%h expected 00 00", dx, dy);
      end
      cnt = 0;
      while (busy && cnt < 100) begin cnt++; tick(); end
      n_checks++;
      if (cnt >= 100) begin n_fail++; $display("FAIL startup_clear: busy never fell"); end
      clear_model();
      mbank = 0;
      // Preload nonzero data in both banks, leave pointer on bank 1.
      for (int a = 0; a < 32; a++) do_wr(a, 8'(a * 7 + 1));
      do_adv();
      for (int a = 0; a < 32; a++) do_wr(a, 8'(a + 8'h80));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_model();
      mbank = 0;
      cnt = 0;
      while (busy && cnt < 100) begin
         adrx = cnt[4:0]; adry = ~cnt[4:0];
         #1;
         n_checks++;
         if (bank !== 1'b0 || dx !== 8'h00 || dy !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_outputs: cycle %0d got bank=%0d dx=%h dy=%h expected 0 00 00",
                     cnt, bank, dx, dy);
         end
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt !== 32) begin n_fail++; $display("FAIL reset_clear_len: got %0d expected 32", cnt); end
      for (int b = 0; b < 2; b++) begin
         for (int a = 0; a < 32; a++) begin
            adrx = 5'(a); adry = 5'(31 - a);
            exp_q.push_back(16'(model[mbank][a]));
            exp_q.push_back(16'(model[mbank][31 - a]));
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (16'(dx) !== e) begin
               n_fail++; $display("FAIL reset_read_x: bank %0d r%0d got %h expected %h", mbank, a, dx, e);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (16'(dy) !== e) begin
               n_fail++;
               $display("FAIL reset_read_y: bank %0d r%0d got %h expected %h", mbank, 31 - a, dy, e);
            end
            tick();
         end
         do_adv();
      end
   endtask

   task automatic test_write_read();
      // Writing cycle: read shows the old value.
      wr = 1'b1; din = 8'hA5; adrx = 5'd3; adry = 5'd3;
      exp_q.push_back(16'(model[mbank][3]));
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (16'(dx) !== e) begin n_fail++; $display("FAIL write_no_bypass: got %h expected %h", dx, e); end
      tick();
      wr = 1'b0;
      model[mbank][3] = 8'hA5;
      do_wr(17, 8'h3C);
      adrx = 5'd3; adry = 5'd17;
      exp_q.push_back(16'h00A5);
      exp_q.push_back(16'h003C);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (16'(dx) !== e) begin n_fail++; $display("FAIL write_read_x: got %h expected %h", dx, e); end
      e = exp_q.pop_front();
      n_checks++;
      if (16'(dy) !== e) begin n_fail++; $display("FAIL write_read_y: got %h expected %h", dy, e); end
      tick();
      adrx = 5'd17; adry = 5'd17;
      exp_q.push_back(16'(model[mbank][17]));
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (16'(dx) !== e || 16'(dy) !== e) begin
         n_fail++; $display("FAIL same_addr: got dx=%h dy=%h expected %h", dx, dy, e);
      end
      tick();
   endtask

   task automatic test_bank_switch();
      do_wr(5, 8'h11);
      adv = 1'b1; wr = 1'b1; din = 8'h22; adrx = 5'd5;
      tick();
      adv = 1'b0; wr = 1'b0;
      model[mbank][5] = 8'h22;
      mbank = (mbank + 1) % 2;
      exp_q.push_back(16'(model[mbank][5]));
      #1;
      n_checks++;
      if (bank !== 1'(mbank)) begin n_fail++; $display("FAIL adv_bank: got %0d expected %0d", bank, mbank); end
      e = exp_q.pop_front();
      n_checks++;
      if (16'(dx) !== e) begin n_fail++; $display("FAIL bank1_r5: got %h expected %h", dx, e); end
      do_adv();
      exp_q.push_back(16'(model[mbank][5]));
      #1;
      n_checks++;
      if (bank !== 1'(mbank)) begin n_fail++; $display("FAIL wrap_bank: got %0d expected %0d", bank, mbank); end
      e = exp_q.pop_front();
      n_checks++;
      if (16'(dx) !== e) begin n_fail++; $display("FAIL bank0_r5: got %h expected %h", dx, e); end
      tick();
   endtask

   task automatic test_busy_writes();
      int cnt;
      do_adv();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         n_checks++;
         if (bank !== 1'(mbank)) begin
            n_fail++; $display("FAIL busy_bank: cycle %0d got %0d expected %0d", cnt, bank, mbank);
         end
         wr = 1'b1; din = 8'hFF; adrx = cnt[4:0]; adv = 1'b1;
         cnt++;
         tick();
      end
      wr = 1'b0; adv = 1'b0;
      clear_model();
      n_checks++;
      if (cnt !== 32) begin n_fail++; $display("FAIL clr_len: got %0d expected 32", cnt); end
      n_checks++;
      if (bank !== 1'(mbank)) begin n_fail++; $display("FAIL clr_bank: got %0d expected %0d", bank, mbank); end
      for (int b = 0; b < 2; b++) begin
         for (int a = 0; a < 32; a++) begin
            adrx = 5'(a); adry = 5'(31 - a);
            exp_q.push_back(16'(model[mbank][a]));
            exp_q.push_back(16'(model[mbank][31 - a]));
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (16'(dx) !== e) begin
               n_fail++; $display("FAIL busy_wr_x: bank %0d r%0d got %h expected %h", mbank, a, dx, e);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (16'(dy) !== e) begin
               n_fail++;
               $display("FAIL busy_wr_y: bank %0d r%0d got %h expected %h", mbank, 31 - a, dy, e);
            end
            tick();
         end
         do_adv();
      end
   endtask

   task automatic test_clr_restart();
      int total;
      int after;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      total = 0;
      after = 0;
      while (busy && total < 200) begin
         total++;
         if (total > 10) after++;
         clr = (total == 10);
         tick();
      end
      clr = 1'b0;
      n_checks++;
      if (total !== 42) begin n_fail++; $display("FAIL restart_total: got %0d expected 42", total); end
      n_checks++;
      if (after !== 32) begin n_fail++; $display("FAIL restart_after: got %0d expected 32", after); end
   endtask

   task automatic test_params();
      int cnt;
      rst2 = 1'b1;
      tick();
      rst2 = 1'b0;
      cnt = 0;
      while (busy2 && cnt < 100) begin cnt++; tick(); end
      n_checks++;
      if (cnt !== 8) begin n_fail++; $display("FAIL sweep_clear_len: got %0d expected 8", cnt); end
      for (int i = 0; i < 3; i++) begin adv2 = 1'b1; tick(); adv2 = 1'b0; tick(); end
      n_checks++;
      if (bank2 !== 2'd3) begin n_fail++; $display("FAIL sweep_bank3: got %0d expected 3", bank2); end
      wr2 = 1'b1; din2 = 16'hBEEF; adrx2 = 3'd7;
      tick();
      wr2 = 1'b0;
      adry2 = 3'd7;
      exp_q.push_back(16'hBEEF);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (dx2 !== e || dy2 !== e) begin
         n_fail++; $display("FAIL sweep_read: got dx=%h dy=%h expected %h", dx2, dy2, e);
      end
      adv2 = 1'b1; tick(); adv2 = 1'b0;
      exp_q.push_back(16'h0000);
      #1;
      n_checks++;
      if (bank2 !== 2'd0) begin n_fail++; $display("FAIL sweep_wrap: got %0d expected 0", bank2); end
      e = exp_q.pop_front();
      n_checks++;
      if (dx2 !== e) begin n_fail++; $display("FAIL sweep_bank0_r7: got %h expected %h", dx2, e); end
      for (int i = 0; i < 3; i++) begin adv2 = 1'b1; tick(); adv2 = 1'b0; tick(); end
      exp_q.push_back(16'hBEEF);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (bank2 !== 2'd3 || dx2 !== e) begin
         n_fail++; $display("FAIL sweep_return: got bank=%0d dx=%h expected 3 %h", bank2, dx2, e);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bank_switch();
      test_busy_writes();
      test_clr_restart();
      test_params();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
